// File: rtl/onfi_pkg.sv
// Shared definitions for the ONFI status poller: command opcodes, FSM encoding
// and the row-address byte selector.
package onfi_pkg;

  localparam logic [7:0] CMD_READ_STATUS     = 8'h70;
  localparam logic [7:0] CMD_READ_STATUS_ENH = 8'h78;
  localparam int         ROW_BYTES           = 3;
  localparam int         STATUS_RDY_BIT      = 6;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CMD_LO = 4'd1,
    CMD_HI = 4'd2,
    ADR_LO = 4'd3,
    ADR_HI = 4'd4,
    WHR    = 4'd5,
    RE_LO  = 4'd6,
    RE_HI  = 4'd7,
    CHECK  = 4'd8,
    GAP    = 4'd9,
    DONE   = 4'd10
  } onfi_state_e;

  function automatic logic [7:0] row_byte(input logic [23:0] row, input logic [1:0] idx);
    case (idx)
      2'd0:    return row[7:0];
      2'd1:    return row[15:8];
      default: return row[23:16];
    endcase
  endfunction

endpackage

// File: rtl/onfi_cycle_timer.sv
// Loadable down-counter with a zero flag; used for the tWHR and poll-gap waits.
module onfi_cycle_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/onfi_status_poll.sv
// Issues ONFI Read Status (70h) or Read Status Enhanced (78h) to one target and
// polls the status byte until RDY (bit 6) is set or the timeout expires.
module onfi_status_poll
  import onfi_pkg::*;
#(
  parameter int DQ_W        = 8,
  parameter int NUM_CE      = 4,
  parameter int TWHR_CYC    = 12,
  parameter int POLL_GAP    = 8,
  parameter int TIMEOUT_CYC = 100000,
  localparam int CE_W       = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic              onfi_clk,
  input  logic              onfi_rst_n,
  input  logic              start,
  input  logic [CE_W-1:0]   ce_sel,
  input  logic              enhanced,
  input  logic [23:0]       row_addr,
  output logic              busy,
  output logic              done,
  output logic [7:0]        status,
  output logic              timeout,
  output logic              sel_err,
  output logic [NUM_CE-1:0] onfi_cen,
  output logic              onfi_cle,
  output logic              onfi_ale,
  output logic              onfi_wen,
  output logic              onfi_ren,
  output logic [DQ_W-1:0]   onfi_dq_o,
  output logic              onfi_dq_en,
  input  logic [DQ_W-1:0]   onfi_dq_i,
  output logic [3:0]        dbg_state
);

  localparam int TMR_MAX = (TWHR_CYC > POLL_GAP) ? TWHR_CYC : POLL_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  onfi_state_e      r_state, w_next;
  logic [CE_W-1:0]  r_ce;
  logic             r_enh;
  logic [23:0]      r_row;
  logic [1:0]       r_adr_idx;
  logic [7:0]       r_status;
  logic             r_timeout;
  logic             r_sel_err;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_accept;
  logic             w_bad_sel;
  logic             w_active;
  logic             w_to_hit;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic [7:0]       w_opcode;

  // start is a request pulse sampled only in IDLE; busy high means not ready,
  // and a start seen while busy is dropped rather than queued.
  assign w_accept  = (r_state == IDLE) && start;
  assign w_bad_sel = (int'(ce_sel) >= NUM_CE);
  assign w_to_hit  = (r_to_cnt >= TO_MAX);
  assign w_active  = (r_state != IDLE) && (r_state != DONE);
  assign w_opcode  = r_enh ? CMD_READ_STATUS_ENH : CMD_READ_STATUS;

  always_ff @(posedge onfi_clk or negedge onfi_rst_n) begin
    if (!onfi_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_bad_sel ? DONE : CMD_LO;
      CMD_LO:  w_next = CMD_HI;
      CMD_HI:  w_next = r_enh ? ADR_LO : WHR;
      ADR_LO:  w_next = ADR_HI;
      ADR_HI:  w_next = (r_adr_idx == 2'(ROW_BYTES - 1)) ? WHR : ADR_LO;
      WHR:     if (w_tmr_zero) w_next = RE_LO;
      RE_LO:   w_next = RE_HI;
      RE_HI:   w_next = CHECK;
      CHECK:   w_next = (r_status[STATUS_RDY_BIT] || w_to_hit) ? DONE : GAP;
      GAP:     if (w_tmr_zero) w_next = RE_LO;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge onfi_clk or negedge onfi_rst_n) begin
    if (!onfi_rst_n) begin
      r_ce      <= '0;
      r_enh     <= 1'b0;
      r_row     <= '0;
      r_adr_idx <= '0;
      r_status  <= '0;
      r_timeout <= 1'b0;
      r_sel_err <= 1'b0;
      r_to_cnt  <= '0;
    end else if (w_accept) begin
      r_ce      <= ce_sel;
      r_enh     <= enhanced;
      r_row     <= row_addr;
      r_adr_idx <= '0;
      r_status  <= '0;
      r_timeout <= 1'b0;
      r_sel_err <= w_bad_sel;
      r_to_cnt  <= '0;
    end else begin
      if ((r_state != IDLE) && (r_to_cnt != TO_MAX)) r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state == RE_LO) r_status <= onfi_dq_i[7:0];
      if (r_state == ADR_HI) r_adr_idx <= r_adr_idx + 1'b1;
      // Ready wins over timeout when both hold in the same CHECK cycle.
      if ((r_state == CHECK) && !r_status[STATUS_RDY_BIT] && w_to_hit) r_timeout <= 1'b1;
    end
  end

  assign w_tmr_load = ((w_next == WHR) && (r_state != WHR)) ||
                      ((w_next == GAP) && (r_state != GAP));
  assign w_tmr_val  = (w_next == WHR) ? TMR_W'(TWHR_CYC - 1) : TMR_W'(POLL_GAP - 1);

  onfi_cycle_timer #(.W(TMR_W)) u_timer (
    .i_clk      (onfi_clk),
    .i_rst_n    (onfi_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    onfi_cen   = '1;
    onfi_cle   = 1'b0;
    onfi_ale   = 1'b0;
    onfi_wen   = 1'b1;
    onfi_ren   = 1'b1;
    onfi_dq_en = 1'b0;
    onfi_dq_o  = '0;
    for (int i = 0; i < NUM_CE; i++) begin
      if (w_active && (int'(r_ce) == i)) onfi_cen[i] = 1'b0;
    end
    case (r_state)
      CMD_LO, CMD_HI: begin
        onfi_cle       = 1'b1;
        onfi_wen       = (r_state == CMD_HI);
        onfi_dq_en     = 1'b1;
        onfi_dq_o[7:0] = w_opcode;
      end
      ADR_LO, ADR_HI: begin
        onfi_ale       = 1'b1;
        onfi_wen       = (r_state == ADR_HI);
        onfi_dq_en     = 1'b1;
        onfi_dq_o[7:0] = row_byte(r_row, r_adr_idx);
      end
      RE_LO:   onfi_ren = 1'b0;
      default: ;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign status    = r_status;
  assign timeout   = r_timeout;
  assign sel_err   = r_sel_err;
  assign dbg_state = r_state;

endmodule
